// File: rtl/hdmi_bringup_seq.sv
// HDMI link bring-up sequencer: PLL reset, lock qualification, divider and pixel reset release,
// TMDS enable, with bounded retries and a fault state.
module hdmi_bringup_seq #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1048576,
  parameter int unsigned SETTLE_CYCLES       = 16,
  parameter int unsigned MAX_RETRY           = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pll_lock,
  input  logic       restart,
  output logic       pll_reset,
  output logic       div_resetn,
  output logic       pix_resetn,
  output logic       tmds_oe,
  output logic       ready,
  output logic       fault,
  output logic [2:0] state,
  output logic [3:0] retry_cnt
);

  localparam int unsigned MaxA = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ?
                                 PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int unsigned MaxB = (LOCK_TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                                 LOCK_TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxCnt = (MaxA > MaxB) ? MaxA : MaxB;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  // Counter loads are N-1 so a state lasts exactly N cycles.
  localparam logic [CntW-1:0] RstLoad     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLoad = CntW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] StableLoad  = CntW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad  = CntW'(SETTLE_CYCLES - 1);
  localparam logic [3:0]      MaxRetry    = 4'(MAX_RETRY);

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StPllRst     = 3'd1,
    StWaitLock   = 3'd2,
    StLockStable = 3'd3,
    StDivEn      = 3'd4,
    StPixEn      = 3'd5,
    StRun        = 3'd6,
    StFault      = 3'd7
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d, retry_inc;
  logic            lock_meta_q, lock_s_q;
  state_e          fail_st;

  always_comb begin
    retry_inc = (retry_q == 4'd15) ? 4'd15 : retry_q + 4'd1;
    fail_st   = (retry_inc == MaxRetry) ? StFault : StPllRst;
    state_d   = state_q;
    cnt_d     = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    retry_d   = retry_q;
    if (restart) begin
      state_d = StPllRst;
      cnt_d   = RstLoad;
      retry_d = 4'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StPllRst;
          cnt_d   = RstLoad;
        end
        StPllRst: begin
          if (cnt_q == '0) begin
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end
        end
        StWaitLock: begin
          if (lock_s_q) begin
            state_d = StLockStable;
            cnt_d   = StableLoad;
          end else if (cnt_q == '0) begin
            state_d = fail_st;
            cnt_d   = RstLoad;
            retry_d = retry_inc;
          end
        end
        StLockStable: begin
          // A glitch only restarts qualification; it does not count as a failed attempt.
          if (!lock_s_q) begin
            state_d = StWaitLock;
            cnt_d   = TimeoutLoad;
          end else if (cnt_q == '0) begin
            state_d = StDivEn;
            cnt_d   = SettleLoad;
          end
        end
        StDivEn, StPixEn, StRun: begin
          if (!lock_s_q) begin
            state_d = fail_st;
            cnt_d   = RstLoad;
            retry_d = retry_inc;
          end else if (state_q == StDivEn && cnt_q == '0) begin
            state_d = StPixEn;
            cnt_d   = SettleLoad;
          end else if (state_q == StPixEn && cnt_q == '0) begin
            state_d = StRun;
            retry_d = 4'd0;
          end
        end
        StFault: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs are registered from the next state so they always match state_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      retry_q     <= 4'd0;
      pll_reset   <= 1'b1;
      div_resetn  <= 1'b0;
      pix_resetn  <= 1'b0;
      tmds_oe     <= 1'b0;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      lock_meta_q <= pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset   <= (state_d == StPllRst);
      div_resetn  <= (state_d == StDivEn) || (state_d == StPixEn) || (state_d == StRun);
      pix_resetn  <= (state_d == StPixEn) || (state_d == StRun);
      tmds_oe     <= (state_d == StRun);
      ready       <= (state_d == StRun);
      fault       <= (state_d == StFault);
    end
  end

  assign state     = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_hdmi_bringup_seq.sv
// Bench for hdmi_bringup_seq: checkpoint table for bring-up, lock loss and glitch, plus
// hand-written sequences for timeout-to-fault, restart races and asynchronous reset.
module tb_hdmi_bringup_seq;

  localparam int unsigned PRst    = 16;
  localparam int unsigned PStable = 64;
  localparam int unsigned PTo     = 128;
  localparam int unsigned PSettle = 16;
  localparam int unsigned PMax    = 3;

  logic       clk, resetn, pll_lock, restart;
  logic       pll_reset, div_resetn, pix_resetn, tmds_oe, ready, fault;
  logic [2:0] state;
  logic [3:0] retry_cnt;

  hdmi_bringup_seq #(
    .PLL_RST_CYCLES     (PRst),
    .LOCK_STABLE_CYCLES (PStable),
    .LOCK_TIMEOUT_CYCLES(PTo),
    .SETTLE_CYCLES      (PSettle),
    .MAX_RETRY          (PMax)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .pll_lock  (pll_lock),
    .restart   (restart),
    .pll_reset (pll_reset),
    .div_resetn(div_resetn),
    .pix_resetn(pix_resetn),
    .tmds_oe   (tmds_oe),
    .ready     (ready),
    .fault     (fault),
    .state     (state),
    .retry_cnt (retry_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         lock;
    bit         rst;
    int         ncyc;
    logic [2:0] st;
    logic [3:0] rc;
  } vec_t;

  typedef struct {
    string       name;
    logic [12:0] v;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected outputs for a state: IDLE carries the reset value of pll_reset.
  function automatic logic [12:0] mk(logic [2:0] st, logic [3:0] rc);
    logic prst, div, pix, run, flt;
    prst = (st == 3'd0) || (st == 3'd1);
    div  = (st == 3'd4) || (st == 3'd5) || (st == 3'd6);
    pix  = (st == 3'd5) || (st == 3'd6);
    run  = (st == 3'd6);
    flt  = (st == 3'd7);
    return {st, rc, prst, div, pix, run, run, flt};
  endfunction

  function automatic logic [12:0] outs();
    return {state, retry_cnt, pll_reset, div_resetn, pix_resetn, tmds_oe, ready, fault};
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string nm, logic [2:0] st, logic [3:0] rc);
    exp_t e;
    e.name = nm;
    e.v    = mk(st, rc);
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [12:0] got;
    got = outs();
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: got %b with nothing expected", got);
    end else begin
      e = sb.pop_front();
      if (got !== e.v) begin
        n_bad++;
        $display("FAIL %s: got {st,rc,prst,div,pix,oe,rdy,flt}=%b required %b",
                 e.name, got, e.v);
      end
    end
  endtask

  task automatic cmp(string nm, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, got, exp);
    end
  endtask

  task automatic add(string nm, bit lk, bit rs, int n, logic [2:0] st, logic [3:0] rc);
    vec_t v;
    v.name = nm; v.lock = lk; v.rst = rs; v.ncyc = n; v.st = st; v.rc = rc;
    tbl.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int falls, cyc;
    logic prev;

    // Edge numbers in names count posedges after reset release. Lock appears 100 cycles after
    // the PLL reset pulse, so ready is due 16+100+2+64+16+16 = 214 (+1 entry cycle) -> 215.
    add("pllrst_e1",       0, 0, 1,  3'd1, 4'd0);
    add("pllrst_e16",      0, 0, 15, 3'd1, 4'd0);
    add("waitlock_e17",    0, 0, 1,  3'd2, 4'd0);
    add("waitlock_e116",   0, 0, 99, 3'd2, 4'd0);
    add("sync_lat_e118",   1, 0, 2,  3'd2, 4'd0);
    add("stable_e119",     1, 0, 1,  3'd3, 4'd0);
    add("stable_e182",     1, 0, 63, 3'd3, 4'd0);
    add("diven_e183",      1, 0, 1,  3'd4, 4'd0);
    add("pixen_e199",      1, 0, 16, 3'd5, 4'd0);
    add("pixen_e214",      1, 0, 15, 3'd5, 4'd0);
    add("run_e215",        1, 0, 1,  3'd6, 4'd0);
    add("run_e225",        1, 0, 10, 3'd6, 4'd0);
    // Lock drops after edge 225: still RUN two edges later, PLL_RST on the third.
    add("loss_e227",       0, 0, 2,  3'd6, 4'd0);
    add("loss_e228",       0, 0, 1,  3'd1, 4'd1);
    add("loss_rst_e243",   0, 0, 15, 3'd1, 4'd1);
    add("loss_wait_e244",  0, 0, 1,  3'd2, 4'd1);
    add("relock_e247",     1, 0, 3,  3'd3, 4'd1);
    add("relock_div_e311", 1, 0, 64, 3'd4, 4'd1);
    add("relock_run_e343", 1, 0, 32, 3'd6, 4'd0);
    // Restart from RUN, then a 5-cycle lock glitch during LOCK_STABLE.
    add("restart_e344",    1, 1, 1,  3'd1, 4'd0);
    add("restart_w_e360",  1, 0, 16, 3'd2, 4'd0);
    add("stable2_e361",    1, 0, 1,  3'd3, 4'd0);
    add("stable2_e371",    1, 0, 10, 3'd3, 4'd0);
    add("glitch_e374",     0, 0, 3,  3'd2, 4'd0);
    add("glitch_e376",     0, 0, 2,  3'd2, 4'd0);
    add("requal_e379",     1, 0, 3,  3'd3, 4'd0);
    add("requal_e442",     1, 0, 63, 3'd3, 4'd0);
    add("requal_div_e443", 1, 0, 1,  3'd4, 4'd0);

    resetn = 1'b0; pll_lock = 1'b0; restart = 1'b0;
    #12;
    push("reset_state", 3'd0, 4'd0);
    pop_check();
    tick(1);
    resetn = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      pll_lock = tbl[i].lock;
      restart  = tbl[i].rst;
      push(tbl[i].name, tbl[i].st, tbl[i].rc);
      tick(tbl[i].ncyc);
      pop_check();
    end

    // Reach RUN again, then assert reset mid-cycle.
    push("run_before_areset", 3'd6, 4'd0);
    tick(32);
    pop_check();
    #2;
    resetn = 1'b0;
    #1;
    push("async_reset_in_run", 3'd0, 4'd0);
    pop_check();
    cmp("async_reset_oe", int'(tmds_oe), 0);

    // Lock never asserts: three PLL reset pulses, then FAULT after the third timeout.
    pll_lock = 1'b0;
    tick(1);
    resetn = 1'b1;
    falls = 0;
    cyc   = 0;
    prev  = pll_reset;
    while (fault !== 1'b1 && cyc < 2000) begin
      tick(1);
      cyc++;
      if (prev === 1'b1 && pll_reset === 1'b0) falls++;
      prev = pll_reset;
    end
    cmp("fault_cycle", cyc, 433);
    cmp("pll_rst_pulses", falls, 3);
    push("fault_state", 3'd7, 4'd3);
    pop_check();
    push("fault_hold", 3'd7, 4'd3);
    tick(20);
    pop_check();

    // Restart out of FAULT.
    restart = 1'b1;
    push("restart_from_fault", 3'd1, 4'd0);
    tick(1);
    restart = 1'b0;
    pop_check();

    // Restart landing on the same edge as a lock timeout: restart wins, retry_cnt stays 0.
    push("pre_timeout_wait", 3'd2, 4'd0);
    tick(142);
    pop_check();
    tick(1);
    restart = 1'b1;
    push("restart_vs_timeout", 3'd1, 4'd0);
    tick(1);
    restart = 1'b0;
    pop_check();
    push("after_race_wait", 3'd2, 4'd0);
    tick(16);
    pop_check();

    cmp("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
